// File: rtl/dmux_pkg.sv
// Shared encodings for the round-robin demultiplexer: FSM states, channel count and helpers.
package dmux_pkg;

   localparam int unsigned NCH = 4;

   typedef logic [NCH-1:0] chmask_t;
   typedef logic [1:0]     chan_t;
   typedef logic [1:0]     state_t;

   localparam state_t IDLE = 2'd0;
   localparam state_t ARB  = 2'd1;
   localparam state_t XFER = 2'd2;

   // Rotation wraps 3 -> 0 through the natural 2-bit overflow.
   function automatic chan_t next_chan(input chan_t c);
      return c + 2'd1;
   endfunction

endpackage

// File: rtl/dmux_rr_ptr.sv
// Round-robin grant search: first enabled channel at or after ptr, wrapping modulo NCH.
module dmux_rr_ptr
   import dmux_pkg::*;
(
   input  chan_t   ptr,
   input  chmask_t chan_en,
   output chan_t   grant,
   output logic    found
);

   always_comb begin
      grant = ptr;
      found = 1'b0;
      for (int i = 0; i < NCH; i++) begin
         if (!found && chan_en[ptr + 2'(i)]) begin
            grant = ptr + 2'(i);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/dmux_rr_ctrl.sv
// Round-robin demultiplexer: steers bursts of up to BURST words from one input stream
// to four output channels through a single shared output register.
module dmux_rr_ctrl
   import dmux_pkg::*;
#(
   parameter int unsigned DW    = 8,
   parameter int unsigned BURST = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   input  logic [3:0]    chan_en,
   input  logic          in_valid,
   input  logic [DW-1:0] in_data,
   input  logic          in_last,
   output logic          in_ready,
   output logic [3:0]    out_valid,
   output logic [DW-1:0] out_data,
   input  logic [3:0]    out_ready,
   output logic [1:0]    sel,
   output logic          busy
);

   localparam int unsigned   CW      = $clog2(BURST) + 1;
   localparam logic [CW-1:0] BURST_C = CW'(BURST);

   state_t        state_q, state_d;
   chan_t         ptr_q, ptr_d;
   chan_t         sel_q, sel_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          open_q, open_d;
   logic          buf_valid_q, buf_valid_d;
   logic [DW-1:0] data_q, data_d;

   chan_t         grant;
   logic          found;
   logic          sel_ready;
   logic          accept;
   logic          leave;
   logic [CW-1:0] cnt_inc;

   dmux_rr_ptr u_rr_ptr (
      .ptr     (ptr_q),
      .chan_en (chan_en),
      .grant   (grant),
      .found   (found)
   );

   // Ready from non-selected channels never reaches the handshake.
   assign sel_ready = out_ready[sel_q];
   assign in_ready  = (state_q == XFER) && open_q && (!buf_valid_q || sel_ready);
   assign accept    = in_valid && in_ready;
   assign leave     = buf_valid_q && sel_ready;
   assign cnt_inc   = cnt_q + 1'b1;

   assign busy     = (state_q == ARB) || (state_q == XFER);
   assign sel      = sel_q;
   assign out_data = data_q;

   always_comb begin
      out_valid        = '0;
      out_valid[sel_q] = buf_valid_q;
   end

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      sel_d       = sel_q;
      cnt_d       = cnt_q;
      open_d      = open_q;
      buf_valid_d = buf_valid_q;
      data_d      = data_q;
      unique case (state_q)
         IDLE: begin
            if (en) state_d = ARB;
         end
         ARB: begin
            if (!en) begin
               state_d = IDLE;
            end else if (found) begin
               state_d = XFER;
               sel_d   = grant;
               cnt_d   = '0;
               open_d  = 1'b1;
            end
         end
         XFER: begin
            if (accept) begin
               data_d      = in_data;
               buf_valid_d = 1'b1;
               cnt_d       = cnt_inc;
               if (in_last || (cnt_inc == BURST_C)) open_d = 1'b0;
            end else if (leave) begin
               buf_valid_d = 1'b0;
            end
            // Rotate as soon as the closed burst's last word drains.
            if (!open_q && (!buf_valid_q || leave)) begin
               state_d = ARB;
               ptr_d   = next_chan(sel_q);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         sel_q       <= '0;
         cnt_q       <= '0;
         open_q      <= 1'b0;
         buf_valid_q <= 1'b0;
         data_q      <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         sel_q       <= sel_d;
         cnt_q       <= cnt_d;
         open_q      <= open_d;
         buf_valid_q <= buf_valid_d;
         data_q      <= data_d;
      end
   end

endmodule

// File: tb/tb_dmux_rr_ctrl.sv
// Self-checking bench for dmux_rr_ctrl: burst-level scoreboard model plus directed scenarios.
module tb_dmux_rr_ctrl;

   localparam int unsigned DW    = 8;
   localparam int unsigned BURST = 4;

   logic          clk       = 1'b0;
   logic          rst_n     = 1'b1;
   logic          en        = 1'b0;
   logic [3:0]    chan_en   = 4'h0;
   logic          in_valid  = 1'b0;
   logic [DW-1:0] in_data   = '0;
   logic          in_last   = 1'b0;
   logic [3:0]    out_ready = 4'hF;
   logic          in_ready;
   logic [3:0]    out_valid;
   logic [DW-1:0] out_data;
   logic [1:0]    sel;
   logic          busy;

   always #5 clk = ~clk;

   dmux_rr_ctrl #(.DW(DW), .BURST(BURST)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .chan_en   (chan_en),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .sel       (sel),
      .busy      (busy)
   );

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Model: each accepted word is assigned a channel from the round-robin rules alone.
   typedef struct packed {
      logic [1:0]    ch;
      logic [DW-1:0] d;
   } word_t;

   word_t         exp_q[$];
   logic [DW-1:0] rx[4][$];
   int            acc_cyc[$];
   int            lv_cyc[$];
   int            m_ptr  = 0;
   bit            m_open = 1'b0;
   int            m_chan = 0;
   int            m_cnt  = 0;
   int            n_acc  = 0;
   int            n_lv   = 0;
   bit            p_acc  = 1'b0;
   int            p_chan = 0;
   logic [DW-1:0] p_data = '0;
   bit            p_hold = 1'b0;
   logic [DW-1:0] p_hold_data = '0;

   function automatic int first_en(input int from, input logic [3:0] m);
      for (int i = 0; i < 4; i++) if (m[(from + i) % 4]) return (from + i) % 4;
      return 0;
   endfunction

   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         m_ptr  = 0;
         m_open = 1'b0;
         m_cnt  = 0;
         p_acc  = 1'b0;
         p_hold = 1'b0;
      end else begin : mon
         logic  lv;
         logic  ac;
         word_t w;
         if (p_acc) begin
            chk("latency_valid", 32'(out_valid), 32'(4'b1 << p_chan));
            chk("latency_data", 32'(out_data), 32'(p_data));
         end else if (p_hold) begin
            chk("hold_data", 32'(out_data), 32'(p_hold_data));
         end
         chk("valid_vs_model", 32'(out_valid != 0), 32'(exp_q.size() != 0));
         if (out_valid != 0) chk("onehot_at_sel", 32'(out_valid), 32'(4'b1 << sel));
         lv = (out_valid & out_ready) != 0;
         ac = in_valid && in_ready;
         if (lv) begin
            if (exp_q.size() == 0) begin
               chk("leave_unexpected", 32'(out_valid), 32'h0);
            end else begin
               w = exp_q.pop_front();
               chk("leave_chan", 32'(out_valid), 32'(4'b1 << w.ch));
               chk("leave_data", 32'(out_data), 32'(w.d));
               rx[w.ch].push_back(out_data);
               lv_cyc.push_back(cyc);
               n_lv++;
            end
         end
         if (ac) begin
            if (!m_open) begin
               m_chan = first_en(m_ptr, chan_en);
               m_open = 1'b1;
               m_cnt  = 0;
            end
            m_cnt++;
            w.ch = 2'(m_chan);
            w.d  = in_data;
            exp_q.push_back(w);
            acc_cyc.push_back(cyc);
            n_acc++;
            if (m_cnt == BURST || in_last) begin
               m_open = 1'b0;
               m_ptr  = (m_chan + 1) % 4;
            end
         end
         p_acc       = ac;
         p_chan      = m_chan;
         p_data      = in_data;
         p_hold      = (out_valid != 0) && !lv && !ac;
         p_hold_data = out_data;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int n, input logic [DW-1:0] base, input int last_idx);
      bit done;
      int budget;
      for (int i = 0; i < n; i++) begin
         done     = 1'b0;
         budget   = 0;
         in_valid = 1'b1;
         in_data  = base + DW'(i);
         in_last  = (i == last_idx);
         while (!done) begin
            @(negedge clk);
            done = in_ready;
            tick();
            budget++;
            if (!done && budget > 100) begin
               chk("send_timeout", 32'(in_ready), 32'h1);
               in_valid = 1'b0;
               in_last  = 1'b0;
               return;
            end
         end
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic drain();
      int b;
      b = 0;
      while (exp_q.size() != 0 && b < 60) begin
         tick();
         b++;
      end
      chk("drain_pending", 32'(exp_q.size()), 32'h0);
   endtask

   task automatic do_reset(input logic [3:0] mask);
      en        = 1'b0;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 4'hF;
      rst_n     = 1'b0;
      @(negedge clk);
      tick();
      chan_en = mask;
      rst_n   = 1'b1;
      for (int k = 0; k < 4; k++) rx[k].delete();
      acc_cyc.delete();
      lv_cyc.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int base_acc;
      int base_lv;
      bit got;
      int b;

      // Reset values
      #1 rst_n = 1'b0;
      #11;
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_in_ready", 32'(in_ready), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_sel", 32'(sel), 32'h0);
      chk("rst_out_data", 32'(out_data), 32'h0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("idle_en0_busy", 32'(busy), 32'h0);

      // Four full bursts in channel order
      do_reset(4'hF);
      en = 1'b1;
      send(16, 8'h00, -1);
      drain();
      for (int k = 0; k < 4; k++) begin
         chk("rr_count", 32'(rx[k].size()), 32'h4);
         for (int j = 0; j < 4; j++)
            if (rx[k].size() > j) chk("rr_word", 32'(rx[k][j]), 32'(4 * k + j));
      end
      if (acc_cyc.size() >= 4 && lv_cyc.size() >= 1) begin
         chk("back_to_back", 32'(acc_cyc[3] - acc_cyc[0]), 32'h3);
         chk("latency_one", 32'(lv_cyc[0] - acc_cyc[0]), 32'h1);
      end

      // Channels 0 and 2 only
      do_reset(4'b0101);
      en = 1'b1;
      send(16, 8'h20, -1);
      drain();
      chk("mask_ch0_count", 32'(rx[0].size()), 32'h8);
      chk("mask_ch2_count", 32'(rx[2].size()), 32'h8);
      chk("mask_ch1_count", 32'(rx[1].size()), 32'h0);
      chk("mask_ch3_count", 32'(rx[3].size()), 32'h0);
      if (rx[2].size() > 0) chk("mask_ch2_first", 32'(rx[2][0]), 32'h24);
      if (rx[0].size() > 4) chk("mask_ch0_second", 32'(rx[0][4]), 32'h28);

      // Back-pressure for 5 cycles mid-burst
      do_reset(4'hF);
      en       = 1'b1;
      base_acc = n_acc;
      base_lv  = n_lv;
      fork
         send(8, 8'h40, -1);
         begin
            b = 0;
            while (n_acc < base_acc + 2 && b < 50) begin
               tick();
               b++;
            end
            out_ready = 4'b1110;
            for (int c = 0; c < 5; c++) begin
               @(negedge clk);
               chk("stall_in_ready", 32'(in_ready), 32'h0);
               chk("stall_out_valid", 32'(out_valid), 32'h1);
               tick();
            end
            out_ready = 4'hF;
         end
      join
      drain();
      chk("stall_delivered", 32'(n_lv - base_lv), 32'h8);
      chk("stall_ch0_count", 32'(rx[0].size()), 32'h4);
      if (rx[0].size() > 1) chk("stall_ch0_word1", 32'(rx[0][1]), 32'h41);
      if (rx[1].size() > 0) chk("stall_ch1_first", 32'(rx[1][0]), 32'h44);

      // Early close with in_last on the 2nd word
      do_reset(4'hF);
      en = 1'b1;
      send(6, 8'h60, 1);
      drain();
      chk("last_ch0_count", 32'(rx[0].size()), 32'h2);
      chk("last_ch1_count", 32'(rx[1].size()), 32'h4);
      if (rx[1].size() > 0) chk("last_ch1_first", 32'(rx[1][0]), 32'h62);

      // Reset while a word sits in the buffer
      do_reset(4'hF);
      en        = 1'b1;
      out_ready = 4'h0;
      send(1, 8'h80, -1);
      @(negedge clk);
      chk("buffered_before_rst", 32'(out_valid), 32'h1);
      tick();
      #1 rst_n = 1'b0;
      #1;
      chk("async_rst_valid", 32'(out_valid), 32'h0);
      chk("async_rst_busy", 32'(busy), 32'h0);
      chk("async_rst_in_ready", 32'(in_ready), 32'h0);
      @(negedge clk);
      tick();
      rst_n     = 1'b1;
      out_ready = 4'hF;
      #1;
      chk("idle_after_release", 32'(busy), 32'h0);
      for (int c = 0; c < 4; c++) tick();
      send(4, 8'h90, -1);
      drain();
      chk("ptr0_after_reset", 32'(rx[0].size()), 32'h4);

      // No channel enabled, then only channel 3
      do_reset(4'h0);
      en = 1'b1;
      tick();
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         chk("noch_busy", 32'(busy), 32'h1);
         chk("noch_in_ready", 32'(in_ready), 32'h0);
         tick();
      end
      chan_en = 4'b1000;
      got     = 1'b0;
      for (int c = 0; c < 2; c++) begin
         tick();
         @(negedge clk);
         if (in_ready && sel == 2'd3) got = 1'b1;
      end
      chk("grant_ch3_within_2", 32'(got), 32'h1);
      tick();
      send(2, 8'hA0, -1);
      drain();
      chk("ch3_count", 32'(rx[3].size()), 32'h2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/dmux_rr_ctrl.md
DMUX_RR_CTRL -- requirements
Module: dmux_rr_ctrl

Interface
REQ-001 Parameter DW, default 8, width of data word.
REQ-002 Parameter BURST, default 4, maximum words sent to one channel before rotation; legal range 1..256.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 Port clk, input, 1, rising-edge clock.
REQ-005 Port rst_n, input, 1, asynchronous active-low reset.
REQ-006 Port en, input, 1, arbitration enable.
REQ-007 Port chan_en, input, 4, per-channel enable mask.
REQ-008 Port in_valid, input, 1, input word valid.
REQ-009 Port in_data, input, DW, input word.
REQ-010 Port in_last, input, 1, marks final word of a burst; ends the burst early.
REQ-011 Port in_ready, output, 1, input word accepted when in_valid and in_ready are both 1.
REQ-012 Port out_valid, output, 4, one-hot valid per channel; out_valid[k] is the only valid bit when channel k is selected.
REQ-013 Port out_data, output, DW, registered word, shared by all channels.
REQ-014 Port out_ready, input, 4, per-channel ready.
REQ-015 Port sel, output, 2, currently granted channel.
REQ-016 Port busy, output, 1, high in states ARB and XFER.

Function
REQ-017 FSM states SHALL be IDLE, ARB, XFER.
REQ-018 IDLE: in_ready=0; go to ARB when en=1.
REQ-019 ARB: grant the first k with chan_en[k]=1, searching ptr, ptr+1, ... modulo 4; set sel=k, clear the word counter and go to XFER next cycle.
REQ-020 ARB with chan_en=0000 SHALL remain in ARB; ARB with en=0 SHALL return to IDLE.
REQ-021 XFER: output buffer is one register stage (buf_valid, out_data).
REQ-022 XFER: in_ready SHALL be 1 while the burst is open AND (buf_valid=0 OR out_ready[sel]=1).
REQ-023 XFER: on acceptance, out_data <= in_data and buf_valid <= 1 on the next edge; latency input-to-output is exactly 1 cycle.
REQ-024 out_valid SHALL equal buf_valid one-hot at bit sel; all other bits 0.
REQ-025 A word leaves the buffer when out_valid[sel]=1 and out_ready[sel]=1; simultaneous leave and accept SHALL sustain one word per cycle.
REQ-026 Burst closes on acceptance of the BURST-th word or of a word with in_last=1, whichever comes first; after close, in_ready=0.
REQ-027 After burst close and buffer empty, go to ARB with ptr=sel+1 modulo 4 (wrap 3->0).
REQ-028 Changes of chan_en or en during XFER SHALL NOT abort the burst; they take effect at the next ARB.
REQ-029 out_ready on non-selected channels SHALL be ignored.
REQ-030 Word counter width SHALL be clog2(BURST)+1; no overflow for BURST=256.

Reset
REQ-031 On rst_n=0: state=IDLE, ptr=0, sel=0, counter=0, buf_valid=0, out_data=0, out_valid=0000, in_ready=0, busy=0.
REQ-032 Reset asserted mid-burst SHALL discard the buffered word; no out_valid pulse after rst_n deassertion until a new word is accepted.
REQ-033 Reset deassertion SHALL be synchronised by the integrator; the block assumes a clean release edge.

Structure
REQ-034 A shared package dmux_pkg SHALL hold the state encoding (IDLE=2'd0, ARB=2'd1, XFER=2'd2) and the channel count constant NCH=4.
REQ-035 One sub-module dmux_rr_ptr SHALL compute the round-robin grant from ptr and chan_en (combinational, plus a found flag).
REQ-036 One-hot expansion of buf_valid onto out_valid SHALL be done inline; no further sub-modules.

Verification
REQ-037 Reset, en=1, chan_en=1111, all out_ready=1, 16 words 0x00..0x0F: channel 0 gets 0x00..0x03, channel 1 gets 0x04..0x07, channel 2 gets 0x08..0x0B, channel 3 gets 0x0C..0x0F; one word per cycle after the 1-cycle latency.
REQ-038 chan_en=0101: bursts alternate between channels 0 and 2; out_valid[1] and out_valid[3] never assert.
REQ-039 out_ready[sel]=0 for 5 cycles mid-burst: out_data holds, in_ready=0 after one word buffered, no word lost or duplicated.
REQ-040 in_last=1 on the 2nd word with BURST=4: the grant rotates after 2 words; the next word goes to sel+1.
REQ-041 rst_n pulsed low during XFER with buf_valid=1: out_valid goes to 0000 immediately (asynchronously); state=IDLE and ptr=0 after release.
REQ-042 chan_en=0000 with en=1: busy=1, in_ready=0 indefinitely; setting chan_en=1000 grants channel 3 within 2 cycles.
